result_capture_ram: RTL and testbench

// Downstream consumer of ctr_block: while ctr_block's enable is high, captures one data word
// per cycle into on-chip RAM. When enable falls, it drains the captured words to the transfer

---
 rtl/result_capture_ram_if.sv | 26 ++
 rtl/result_capture_ram.sv | 171 +++++++++++++++++
 tb/tb_result_capture_ram.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/result_capture_ram_if.sv
// Capture/drain handshake bundle between ctr_block, the capture RAM and the transfer sink.
// The master modport is the environment side; the slave modport is the capture RAM.
interface result_capture_ram_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  enable;
  logic                  ctr_reset;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  tx_ready;
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_last;
  logic                  transfer_done;
  logic                  busy;
  logic                  overrun;

  modport master (
    output enable, ctr_reset, data_in, tx_ready,
    input  tx_valid, tx_data, tx_last, transfer_done, busy, overrun
  );

  modport slave (
    input  enable, ctr_reset, data_in, tx_ready,
    output tx_valid, tx_data, tx_last, transfer_done, busy, overrun
  );
endinterface

// File: rtl/result_capture_ram.sv
// Captures one word per enabled cycle into RAM, then drains the words in bursts through
// a 2-entry output buffer fed by a 1-cycle-latency RAM read.
//   state     | meaning
//   S_IDLE    | armed, waiting for the first enabled cycle
//   S_CAPTURE | writing one word per enabled cycle
//   S_DRAIN   | reading RAM and streaming words to the sink
//   S_DONE    | one-cycle transfer_done pulse
module result_capture_ram #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDRESS_WIDTH   = 14,
  parameter int MAX_RAM_ADDRESS = 16384,
  parameter int BURST_INDEX     = 8
) (
  input logic                 variable_clk_2,
  input logic                 reset_n,
  result_capture_ram_if.slave bus
);

  localparam int CW = ADDRESS_WIDTH + 1;
  localparam int BW = (BURST_INDEX > 1) ? $clog2(BURST_INDEX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  logic [DATA_WIDTH-1:0]   mem [0:MAX_RAM_ADDRESS-1];
  logic [DATA_WIDTH-1:0]   r_rd_data;

  logic [CW-1:0]           r_wr_addr;
  logic [CW-1:0]           r_rd_addr;
  logic [CW-1:0]           r_count;
  logic                    r_overrun;
  logic [BW-1:0]           r_burst_cnt;

  logic                    r_inflight;
  logic                    r_infl_last;
  logic                    r_infl_final;

  logic [DATA_WIDTH-1:0]   r_buf_data  [2];
  logic                    r_buf_last  [2];
  logic                    r_buf_final [2];
  logic                    r_head;
  logic [1:0]              r_occ;

  logic                    w_pop;
  logic                    w_issue;
  logic                    w_issue_last;
  logic                    w_issue_final;
  logic                    w_full;
  logic                    w_tail;
  logic [2:0]              w_credit;
  logic                    w_we;
  logic [ADDRESS_WIDTH-1:0] w_waddr;

  always_comb begin
    w_pop         = (r_occ != 2'd0) && bus.tx_ready;
    w_credit      = {1'b0, r_occ} + {2'b00, r_inflight};
    // Issue only if the word will have a buffer slot when it returns next cycle.
    w_issue       = !bus.ctr_reset && (r_state == S_DRAIN) && (r_rd_addr < r_count) &&
                    (w_credit < (3'd2 + {2'b00, w_pop}));
    w_issue_final = (r_rd_addr == (r_count - CW'(1)));
    w_issue_last  = (r_burst_cnt == '0) || w_issue_final;
    w_full        = (r_wr_addr == CW'(MAX_RAM_ADDRESS - 1));
    w_tail        = r_head ^ r_occ[0];
    w_we          = bus.enable && (bus.ctr_reset || r_state == S_IDLE || r_state == S_CAPTURE);
    w_waddr       = (bus.ctr_reset || r_state == S_IDLE) ? '0 : r_wr_addr[ADDRESS_WIDTH-1:0];
  end

  always_ff @(posedge variable_clk_2 or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (bus.ctr_reset) begin
      w_next_state = bus.enable ? S_CAPTURE : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (bus.enable) w_next_state = S_CAPTURE;
        S_CAPTURE: if (!bus.enable || w_full) w_next_state = S_DRAIN;
        S_DRAIN:   if (w_pop && r_buf_final[r_head]) w_next_state = S_DONE;
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.tx_valid      = (r_occ != 2'd0);
    bus.tx_data       = r_buf_data[r_head];
    bus.tx_last       = (r_occ != 2'd0) && r_buf_last[r_head];
    bus.transfer_done = (r_state == S_DONE);
    bus.busy          = (r_state != S_IDLE);
    bus.overrun       = r_overrun;
  end

  // RAM array and its read register carry no reset.
  always_ff @(posedge variable_clk_2) begin
    if (w_we)    mem[w_waddr] <= bus.data_in;
    if (w_issue) r_rd_data    <= mem[r_rd_addr[ADDRESS_WIDTH-1:0]];
  end

  always_ff @(posedge variable_clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_addr      <= '0;
      r_rd_addr      <= '0;
      r_count        <= '0;
      r_overrun      <= 1'b0;
      r_burst_cnt    <= BW'(BURST_INDEX - 1);
      r_inflight     <= 1'b0;
      r_infl_last    <= 1'b0;
      r_infl_final   <= 1'b0;
      r_buf_data[0]  <= '0;
      r_buf_data[1]  <= '0;
      r_buf_last[0]  <= 1'b0;
      r_buf_last[1]  <= 1'b0;
      r_buf_final[0] <= 1'b0;
      r_buf_final[1] <= 1'b0;
      r_head         <= 1'b0;
      r_occ          <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_infl_last  <= w_issue_last;
        r_infl_final <= w_issue_final;
      end

      if (r_state != S_DRAIN || bus.ctr_reset)
        r_burst_cnt <= BW'(BURST_INDEX - 1);
      else if (w_issue)
        r_burst_cnt <= (r_burst_cnt == '0) ? BW'(BURST_INDEX - 1) : r_burst_cnt - BW'(1);

      if (bus.ctr_reset) begin
        r_rd_addr <= '0;
        r_count   <= '0;
        r_overrun <= 1'b0;
        r_occ     <= 2'd0;
        r_head    <= 1'b0;
        r_wr_addr <= bus.enable ? CW'(1) : '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_rd_addr <= '0;
            if (bus.enable) r_wr_addr <= CW'(1);
          end
          S_CAPTURE: begin
            if (bus.enable) begin
              r_wr_addr <= r_wr_addr + CW'(1);
              if (w_full) r_count <= CW'(MAX_RAM_ADDRESS);
            end else begin
              r_count <= r_wr_addr;
            end
          end
          default: if (bus.enable) r_overrun <= 1'b1;
        endcase

        if (w_issue) r_rd_addr <= r_rd_addr + CW'(1);

        if (r_inflight) begin
          r_buf_data[w_tail]  <= r_rd_data;
          r_buf_last[w_tail]  <= r_infl_last;
          r_buf_final[w_tail] <= r_infl_final;
        end
        if (w_pop) r_head <= ~r_head;
        r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
      end
    end
  end

endmodule

// File: tb/tb_result_capture_ram.sv
// Directed bench for result_capture_ram: a default-size instance and a 16-word instance
// share clock and reset; sel steers stimulus and observation to one of them.
module tb_result_capture_ram;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sel = 1'b0;
  logic       t_enable = 1'b0;
  logic       t_ctr_reset = 1'b0;
  logic       t_rdy = 1'b0;
  logic [7:0] t_data = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  result_capture_ram_if #(.DATA_WIDTH(8)) bus0 ();
  result_capture_ram_if #(.DATA_WIDTH(8)) bus1 ();

  result_capture_ram u_dut (
    .variable_clk_2(clk),
    .reset_n       (reset_n),
    .bus           (bus0)
  );

  result_capture_ram #(
    .ADDRESS_WIDTH  (4),
    .MAX_RAM_ADDRESS(16)
  ) u_dut_small (
    .variable_clk_2(clk),
    .reset_n       (reset_n),
    .bus           (bus1)
  );

  assign bus0.enable    = t_enable & ~sel;
  assign bus1.enable    = t_enable & sel;
  assign bus0.ctr_reset = t_ctr_reset & ~sel;
  assign bus1.ctr_reset = t_ctr_reset & sel;
  assign bus0.tx_ready  = t_rdy & ~sel;
  assign bus1.tx_ready  = t_rdy & sel;
  assign bus0.data_in   = t_data;
  assign bus1.data_in   = t_data;

  logic       m_valid, m_last, m_done, m_busy, m_overrun;
  logic [7:0] m_data;
  assign m_valid   = sel ? bus1.tx_valid      : bus0.tx_valid;
  assign m_data    = sel ? bus1.tx_data       : bus0.tx_data;
  assign m_last    = sel ? bus1.tx_last       : bus0.tx_last;
  assign m_done    = sel ? bus1.transfer_done : bus0.transfer_done;
  assign m_busy    = sel ? bus1.busy          : bus0.busy;
  assign m_overrun = sel ? bus1.overrun       : bus0.overrun;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      t_enable = 1'b1;
      t_data   = base + 8'(i);
      step();
    end
    t_enable = 1'b0;
  endtask

  // Expects words base+0 .. base+n-1, bursts of 8, then a single transfer_done pulse.
  task automatic drain(input int n, input logic [7:0] base, input bit alt, input string tg);
    int         k = 0;
    int         cyc = 0;
    int         first = -1;
    int         last_c = 0;
    bit         stalled = 1'b0;
    bit         rdy;
    logic [7:0] hd = 8'h00;
    logic       hl = 1'b0;
    while (k < n && cyc < 300) begin
      if (stalled) begin
        chk_val({tg, "_stall_valid"}, 32'(m_valid), 32'd1);
        chk_val({tg, "_stall_data"},  32'(m_data),  32'(hd));
        chk_val({tg, "_stall_last"},  32'(m_last),  32'(hl));
      end
      if (m_valid) begin
        chk_val({tg, "_done_with_valid"}, 32'(m_done), 32'd0);
        if (first < 0) first = cyc;
      end
      rdy     = alt ? ((cyc % 2) == 0) : 1'b1;
      t_rdy   = rdy;
      stalled = 1'b0;
      if (m_valid && rdy) begin
        chk_val({tg, "_data"}, 32'(m_data), 32'(base + 8'(k)));
        chk_val({tg, "_last"}, 32'(m_last), 32'(((k + 1) % 8 == 0) || (k == n - 1)));
        k++;
        last_c = cyc;
      end else if (m_valid) begin
        stalled = 1'b1;
        hd      = m_data;
        hl      = m_last;
      end
      step();
      cyc++;
    end
    chk_val({tg, "_word_count"}, 32'(k), 32'(n));
    if (!alt) chk_val({tg, "_gapless"}, 32'(last_c - first + 1), 32'(n));
    chk_val({tg, "_first_latency"}, 32'(first >= 0 && first <= 3), 32'd1);
    chk_val({tg, "_done_pulse"},  32'(m_done),  32'd1);
    chk_val({tg, "_done_valid"},  32'(m_valid), 32'd0);
    t_rdy = 1'b0;
    step();
    chk_val({tg, "_done_cleared"}, 32'(m_done), 32'd0);
    chk_val({tg, "_idle_busy"},    32'(m_busy), 32'd0);
  endtask

  initial begin
    #3;
    chk_val("rst_valid",   32'(bus0.tx_valid),      32'd0);
    chk_val("rst_last",    32'(bus0.tx_last),       32'd0);
    chk_val("rst_done",    32'(bus0.transfer_done), 32'd0);
    chk_val("rst_busy",    32'(bus0.busy),          32'd0);
    chk_val("rst_overrun", 32'(bus0.overrun),       32'd0);
    chk_val("rst_small_busy", 32'(bus1.busy),       32'd0);
    reset_n = 1'b1;
    step();

    // Single-word run.
    capture(1, 8'h3C);
    chk_val("t6_busy", 32'(m_busy), 32'd1);
    drain(1, 8'h3C, 1'b0, "t6");
    chk_val("t6_overrun", 32'(m_overrun), 32'd0);

    // 20 words, sink always ready.
    capture(20, 8'h00);
    drain(20, 8'h00, 1'b0, "t1");

    // 20 words, sink ready every other cycle.
    capture(20, 8'h00);
    drain(20, 8'h00, 1'b1, "t2");

    // Re-arm with a simultaneous capture in the middle of a drain.
    capture(10, 8'h40);
    t_rdy = 1'b1;
    repeat (5) step();
    chk_val("t4_mid_valid", 32'(m_valid), 32'd1);
    t_ctr_reset = 1'b1;
    t_enable    = 1'b1;
    t_data      = 8'hA5;
    t_rdy       = 1'b0;
    step();
    chk_val("t4_valid_after_rearm", 32'(m_valid),   32'd0);
    chk_val("t4_busy_after_rearm",  32'(m_busy),    32'd1);
    chk_val("t4_overrun",           32'(m_overrun), 32'd0);
    t_ctr_reset = 1'b0;
    capture(2, 8'hA6);
    drain(3, 8'hA5, 1'b0, "t4");

    // Asynchronous reset in the middle of a drain with overrun set.
    capture(5, 8'h50);
    t_rdy = 1'b1;
    repeat (4) step();
    t_enable = 1'b1;
    step();
    t_enable = 1'b0;
    t_rdy    = 1'b0;
    step();
    chk_val("t5_pre_valid",   32'(m_valid),   32'd1);
    chk_val("t5_pre_overrun", 32'(m_overrun), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_val("t5_valid",   32'(m_valid),   32'd0);
    chk_val("t5_last",    32'(m_last),    32'd0);
    chk_val("t5_done",    32'(m_done),    32'd0);
    chk_val("t5_busy",    32'(m_busy),    32'd0);
    chk_val("t5_overrun", 32'(m_overrun), 32'd0);
    #2;
    reset_n = 1'b1;
    step();

    // 16-word RAM held enabled for 21 cycles.
    sel   = 1'b1;
    t_rdy = 1'b0;
    step();
    capture(21, 8'h00);
    chk_val("t3_overrun_set", 32'(m_overrun), 32'd1);
    chk_val("t3_busy",        32'(m_busy),    32'd1);
    drain(16, 8'h00, 1'b0, "t3");
    chk_val("t3_overrun_sticky", 32'(m_overrun), 32'd1);
    t_ctr_reset = 1'b1;
    step();
    t_ctr_reset = 1'b0;
    chk_val("t3_overrun_cleared", 32'(m_overrun), 32'd0);
    chk_val("t3_busy_cleared",    32'(m_busy),    32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
